fwd_ctrl: RTL and testbench
===========================

# fwd_ctrl

Pipeline forwarding and hazard controller for the 5-stage MIPS core. It generates the 2-bit `choose` codes that drive the two EX-stage operand `mux3` instances. Code 00 selects the register-file operand, 01 selects the EX/MEM ALU result, and 10 selects the MEM/WB write-back value. The block tracks destination-register info for the ID, EX, MEM and WB stages in its own shadow pipeline, detects load-use hazards, issues a one-cycle stall, and counts stall cycles for performance monitoring.

## Interface
- `REG_BITS`, 5, register-specifier width
- `CNT_WIDTH`, 32, stall counter width
- `clock`  in  1  rising-edge clock
- `reset_n`  in  1  synchronous, active-low reset
- `id_rs`  in  REG_BITS  rs specifier of the instruction in ID
- `id_rt`  in  REG_BITS  rt specifier of the instruction in ID
- `id_dest`  in  REG_BITS  destination register of the instruction in ID (already resolved rd/rt)
- `id_reg_write`  in  1  instruction in ID writes the register file
- `id_mem_read`  in  1  instruction in ID is a load
- `hold`  in  1  global freeze (memory wait); all state held
- `flush`  in  1  kill the instruction in ID (taken branch/jump)
- `fwd_a`  out  2  choose code for the EX operand-A mux3; registered
- `fwd_b`  out  2  choose code for the EX operand-B mux3; registered
- `stall`  out  1  load-use stall: hold PC and IF/ID, bubble into EX
- `stall_count`  out  CNT_WIDTH  saturating count of stall cycles

## Operation
- Shadow pipeline registers:
  - EX stage: `ex_rs`, `ex_rt`, `ex_dest`, `ex_we`, `ex_load`
  - MEM stage: `mem_dest`, `mem_we`, `mem_load`
  - WB stage: `wb_dest`, `wb_we`
- Advance on each rising edge with `hold`=0:
  - EX→MEM and MEM→WB copy unconditionally.
  - ID→EX copies the ID inputs, unless a bubble is inserted.
  - A bubble forces `ex_we`=0 and `ex_load`=0 and clears the specifiers.
- Bubble condition: `stall`=1 or `flush`=1.
- Hazard (combinational): `ex_load`=1 and `ex_dest`≠0 and (`ex_dest`==`id_rs` or `ex_dest`==`id_rt`).
- `stall` = hazard and not `flush` and not `hold`.
- Forward computation runs at the ID→EX edge, for the instruction entering EX. For source `s` (rs→`fwd_a`, rt→`fwd_b`):
  - If `s`≠0 and `ex_we` and `ex_dest`==`s` and not `ex_load`, the code is 01. That producer is in MEM next cycle.
  - Else, if `s`≠0 and `mem_we` and `mem_dest`==`s`, the code is 10. That producer is in WB next cycle; this covers both loads and ALU ops.
  - Else the code is 00.
- On a bubble edge, `fwd_a` and `fwd_b` load 00.
- Priority: the nearer producer (01) beats the farther one (10) when both match.
- Register 0 never forwards and never stalls.
- Code 11 is never driven.
- WB→ID same-cycle dependence is resolved by the register file's write-first behaviour; this block does not handle it.
- `stall_count` increments by 1 on each edge where `stall`=1. It saturates at all-ones and never wraps.

## Timing
- Reset (`reset_n`=0 at an edge) forces, regardless of `hold`/`flush`:
  - all shadow registers to 0
  - `fwd_a`=`fwd_b`=00
  - `stall_count`=0
  - `stall`=0 as a consequence (`ex_load`=0)
- Reset mid-stall drops `stall` in the cycle after the reset edge.
- `fwd_a` and `fwd_b` are valid for the whole EX cycle of the instruction they belong to: one-edge latency from ID.
- `stall` is combinational from registered state plus ID inputs and is valid in the same ID cycle. Each load-use pair stalls for exactly 1 cycle. On the next edge the load moves to MEM and the bubble is in EX; the re-evaluated consumer then gets code 10.
- `hold`=1 freezes all registers, including `fwd_*` and `stall_count`. `stall` is forced to 0 while `hold`=1.
- `flush` and hazard together: `flush` wins. `stall`=0, a bubble enters EX, and the count is unchanged.
- `hold` and `flush` together: `hold` wins. Nothing changes, and the caller keeps `flush` asserted.

## Test plan
- Reset: pulse `reset_n`=0 for 2 cycles with random inputs -> `fwd_a`=`fwd_b`=00, `stall`=0, `stall_count`=0.
- EX distance-1: issue `add $3` (dest 3, we=1), then `sub` with rs=3, rt=4 -> in sub's EX cycle `fwd_a`=01, `fwd_b`=00.
- Distance 2 and priority:
  - `add $3`, then `nop`, then a consumer with rt=3 -> `fwd_b`=10.
  - `add $3`, `or $3`, then a consumer with rs=3 -> `fwd_a`=01.
- Load-use: `lw $5`, then `add` with rs=5 -> `stall`=1 for exactly 1 cycle and `stall_count`=1; then `fwd_a`=10 in add's EX cycle.
- $0 destination: `add $0`, then a consumer with rs=0 -> `fwd_a`=00. `lw $0` + consumer with rs=0 -> `stall`=0.
- Flush and hold:
  - `lw $7` + consumer with rt=7 and `flush`=1 -> `stall`=0, next `fwd_b`=00, count unchanged.
  - `hold`=1 for 3 cycles mid-sequence -> all outputs frozen, then normal resume.

Source files
------------

// File: rtl/fwd_ctrl.sv
// Forwarding and load-use hazard controller for the 5-stage MIPS core.
// Keeps a shadow copy of destination info per stage and drives the EX operand mux3 choose codes.
module fwd_ctrl #(
   parameter int REG_BITS  = 5,
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic [REG_BITS-1:0]  id_rs,
   input  logic [REG_BITS-1:0]  id_rt,
   input  logic [REG_BITS-1:0]  id_dest,
   input  logic                 id_reg_write,
   input  logic                 id_mem_read,
   input  logic                 hold,
   input  logic                 flush,
   output logic [1:0]           fwd_a,
   output logic [1:0]           fwd_b,
   output logic                 stall,
   output logic [CNT_WIDTH-1:0] stall_count
);

   typedef logic [REG_BITS-1:0] reg_t;

   typedef enum logic [1:0] {
      SEL_REG = 2'b00,
      SEL_MEM = 2'b01,
      SEL_WB  = 2'b10
   } choose_t;

   // Shadow pipeline state
   reg_t ex_rs, ex_rt, ex_dest;
   logic ex_we, ex_load;
   reg_t mem_dest;
   logic mem_we, mem_load;
   reg_t wb_dest;
   logic wb_we;

   logic    hazard;
   logic    bubble;
   choose_t fwd_a_next, fwd_b_next;

   // Choose code for one source of the instruction about to enter EX.
   // A load in EX cannot forward yet; the hazard logic delays its consumer one cycle.
   function automatic choose_t fwd_code(input reg_t src,
                                        input reg_t exd, input logic exw, input logic exl,
                                        input reg_t memd, input logic memw);
      choose_t code;
      code = SEL_REG;
      if (src != '0) begin
         if (exw && !exl && exd == src)
            code = SEL_MEM;
         else if (memw && memd == src)
            code = SEL_WB;
      end
      return code;
   endfunction

   assign hazard = ex_load && (ex_dest != '0) && ((ex_dest == id_rs) || (ex_dest == id_rt));
   assign stall  = hazard && !flush && !hold;
   assign bubble = stall || flush;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      fwd_a_next = SEL_REG;
      fwd_b_next = SEL_REG;
      if (!bubble) begin
         fwd_a_next = fwd_code(id_rs, ex_dest, ex_we, ex_load, mem_dest, mem_we);
         fwd_b_next = fwd_code(id_rt, ex_dest, ex_we, ex_load, mem_dest, mem_we);
      end
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         ex_rs       <= '0;
         ex_rt       <= '0;
         ex_dest     <= '0;
         ex_we       <= 1'b0;
         ex_load     <= 1'b0;
         mem_dest    <= '0;
         mem_we      <= 1'b0;
         mem_load    <= 1'b0;
         wb_dest     <= '0;
         wb_we       <= 1'b0;
         fwd_a       <= SEL_REG;
         fwd_b       <= SEL_REG;
         stall_count <= '0;
      end else if (!hold) begin
         mem_dest <= ex_dest;
         mem_we   <= ex_we;
         mem_load <= ex_load;
         wb_dest  <= mem_dest;
         wb_we    <= mem_we;

         if (bubble) begin
            ex_rs   <= '0;
            ex_rt   <= '0;
            ex_dest <= '0;
            ex_we   <= 1'b0;
            ex_load <= 1'b0;
         end else begin
            ex_rs   <= id_rs;
            ex_rt   <= id_rt;
            ex_dest <= id_dest;
            ex_we   <= id_reg_write;
            ex_load <= id_mem_read;
         end

         fwd_a <= fwd_a_next;
         fwd_b <= fwd_b_next;

         if (stall && (stall_count != '1))
            stall_count <= stall_count + CNT_WIDTH'(1);
      end
   end

   // A registered code must name the stage its producer now sits in.
   a_fwd_a_mem : assert property (@(posedge clock) disable iff (!reset_n)
      fwd_a == SEL_MEM |-> (ex_rs != '0 && mem_we && !mem_load && mem_dest == ex_rs));
   a_fwd_b_mem : assert property (@(posedge clock) disable iff (!reset_n)
      fwd_b == SEL_MEM |-> (ex_rt != '0 && mem_we && !mem_load && mem_dest == ex_rt));
   a_fwd_a_wb : assert property (@(posedge clock) disable iff (!reset_n)
      fwd_a == SEL_WB |-> (ex_rs != '0 && wb_we && wb_dest == ex_rs));
   a_fwd_b_wb : assert property (@(posedge clock) disable iff (!reset_n)
      fwd_b == SEL_WB |-> (ex_rt != '0 && wb_we && wb_dest == ex_rt));
   a_no_code3 : assert property (@(posedge clock) disable iff (!reset_n)
      fwd_a != 2'b11 && fwd_b != 2'b11);

endmodule

// File: tb/tb_fwd_ctrl.sv
// Scoreboard bench for fwd_ctrl: hand-derived post-edge codes are queued when each
// ID-cycle is driven and compared after the edge; stall is checked within the cycle.
module tb_fwd_ctrl;
   localparam int CW = 2;

   logic          clock = 1'b0;
   logic          reset_n;
   logic [4:0]    id_rs, id_rt, id_dest;
   logic          id_reg_write, id_mem_read, hold, flush;
   logic [1:0]    fwd_a, fwd_b;
   logic          stall;
   logic [CW-1:0] stall_count;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int step;
      int a;
      int b;
      int cnt;
   } exp_t;
   exp_t sb[$];
   int   step_no = 0;

   fwd_ctrl #(.REG_BITS(5), .CNT_WIDTH(CW)) dut (
      .clock(clock), .reset_n(reset_n),
      .id_rs(id_rs), .id_rt(id_rt), .id_dest(id_dest),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .hold(hold), .flush(flush),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall), .stall_count(stall_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // One ID cycle: drive at negedge, check stall (est<0 skips), queue the
   // post-edge expectation, then compare after the rising edge.
   task automatic cyc(input int rs, input int rt, input int dest, input int we, input int ld,
                      input int hd, input int fl, input int rn,
                      input int est, input int ea, input int eb, input int ec);
      exp_t e;
      @(negedge clock);
      step_no++;
      id_rs        = 5'(rs);
      id_rt        = 5'(rt);
      id_dest      = 5'(dest);
      id_reg_write = we[0];
      id_mem_read  = ld[0];
      hold         = hd[0];
      flush        = fl[0];
      reset_n      = rn[0];
      #1;
      if (est >= 0) check($sformatf("stall@%0d", step_no), int'(stall), est);
      sb.push_back('{step_no, ea, eb, ec});
      @(posedge clock);
      #1;
      e = sb.pop_front();
      check($sformatf("fwd_a@%0d", e.step), int'(fwd_a), e.a);
      check($sformatf("fwd_b@%0d", e.step), int'(fwd_b), e.b);
      check($sformatf("count@%0d", e.step), int'(stall_count), e.cnt);
   endtask

   initial begin
      reset_n = 1'b0;
      {id_rs, id_rt, id_dest, id_reg_write, id_mem_read, hold, flush} = '0;

      // Reset with random inputs, including hold/flush
      for (int i = 0; i < 2; i++)
         cyc($urandom_range(31), $urandom_range(31), $urandom_range(31), $urandom_range(1),
             $urandom_range(1), $urandom_range(1), $urandom_range(1), 0,
             (i == 0) ? -1 : 0, 0, 0, 0);

      //  rs  rt  d  we ld hd fl rn   stall a  b  cnt
      // EX distance 1
      cyc( 1,  2,  3, 1, 0, 0, 0, 1,   0,  0, 0, 0);  // add $3
      cyc( 3,  4,  6, 1, 0, 0, 0, 1,   0,  1, 0, 0);  // sub rs=3
      cyc( 0,  0,  0, 0, 0, 0, 0, 1,   0,  0, 0, 0);  // nop
      // Distance 2
      cyc( 1,  2,  3, 1, 0, 0, 0, 1,   0,  0, 0, 0);  // add $3
      cyc( 0,  0,  0, 0, 0, 0, 0, 1,   0,  0, 0, 0);  // nop
      cyc( 8,  3,  9, 1, 0, 0, 0, 1,   0,  0, 2, 0);  // rt=3 from MEM/WB
      // Priority: nearer producer wins
      cyc( 1,  2,  3, 1, 0, 0, 0, 1,   0,  0, 0, 0);  // add $3
      cyc(10, 11,  3, 1, 0, 0, 0, 1,   0,  0, 0, 0);  // or $3
      cyc( 3, 12, 13, 1, 0, 0, 0, 1,   0,  1, 0, 0);  // rs=3 -> 01
      // Load-use
      cyc( 1,  0,  5, 1, 1, 0, 0, 1,   0,  0, 0, 0);  // lw $5
      cyc( 5,  6,  7, 1, 0, 0, 0, 1,   1,  0, 0, 1);  // add rs=5 stalls
      cyc( 5,  6,  7, 1, 0, 0, 0, 1,   0,  2, 0, 1);  // re-issued, 10
      // Register 0
      cyc( 1,  2,  0, 1, 0, 0, 0, 1,   0,  0, 0, 1);  // add $0
      cyc( 0,  0,  8, 1, 0, 0, 0, 1,   0,  0, 0, 1);  // rs=0
      cyc( 1,  2,  0, 1, 1, 0, 0, 1,   0,  0, 0, 1);  // lw $0
      cyc( 0,  9, 10, 1, 0, 0, 0, 1,   0,  0, 0, 1);  // rs=0, no stall
      // Flush beats hazard
      cyc( 1,  2,  7, 1, 1, 0, 0, 1,   0,  0, 0, 1);  // lw $7
      cyc(11,  7, 12, 1, 0, 0, 1, 1,   0,  0, 0, 1);  // rt=7 + flush
      // Hold freezes everything, even with hazard/flush pending
      cyc( 1,  2,  3, 1, 0, 0, 0, 1,   0,  0, 0, 1);  // add $3
      cyc( 3,  2,  4, 1, 1, 0, 0, 1,   0,  1, 0, 1);  // lw $4, rs=3 -> 01
      cyc( 4,  3, 15, 1, 0, 1, 0, 1,   0,  1, 0, 1);  // hold
      cyc( 4,  3, 15, 1, 0, 1, 1, 1,   0,  1, 0, 1);  // hold + flush
      cyc( 4,  3, 15, 1, 0, 1, 0, 1,   0,  1, 0, 1);  // hold
      cyc( 4,  3, 15, 1, 0, 0, 0, 1,   1,  0, 0, 2);  // resume: stall
      cyc( 4,  3, 15, 1, 0, 0, 0, 1,   0,  2, 0, 2);  // rs=4 from WB path
      // Saturation of the narrow counter
      for (int i = 0; i < 2; i++) begin
         cyc( 1,  2,  5, 1, 1, 0, 0, 1,   0,  0, 0, (i == 0) ? 2 : 3);
         cyc( 5, 15, 16, 1, 0, 0, 0, 1,   1,  0, 0, 3);
         cyc( 5, 15, 16, 1, 0, 0, 0, 1,   0,  2, 0, 3);
      end
      // Reset mid-stall
      cyc( 1,  2,  5, 1, 1, 0, 0, 1,   0,  0, 0, 3);  // lw $5
      cyc( 5,  6,  7, 1, 0, 0, 0, 0,   1,  0, 0, 0);  // stalled, reset edge
      cyc( 5,  6,  7, 1, 0, 0, 0, 1,   0,  0, 0, 0);  // stall dropped

      if (sb.size() != 0) check("scoreboard_drain", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
